// File: rtl/debounce_pkg.sv
// Shared state encoding and counter-width helper for the button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM_HI  = 2'd1,
    PRESSED = 2'd2,
    ARM_LO  = 2'd3
  } state_e;

  // Counters compare against (ms - 1), so $clog2 of the largest interval suffices.
  function automatic int cnt_w_f(input int debounce_ms, input int hold_ms, input int repeat_ms);
    int m;
    m = debounce_ms;
    if (hold_ms > m) m = hold_ms;
    if (repeat_ms > m) m = repeat_ms;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Button bundle: raw inputs and ms timebase in, debounced level/pulses and ms strobe out.
interface button_debouncer_if #(
  parameter int N_BTN = 5
);
  logic             div_clk;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             ms_tick;

  modport master (output div_clk, btn_raw,
                  input  btn_level, btn_press, btn_release, ms_tick);
  modport slave  (input  div_clk, btn_raw,
                  output btn_level, btn_press, btn_release, ms_tick);
endinterface

// File: rtl/debounce_channel.sv
// One debounced button: IDLE/ARM_HI/PRESSED/ARM_LO FSM with registered level and pulses.
// BTN_AUTOREPEAT_EN adds a held-button repeat counter that re-pulses press.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
`ifdef BTN_AUTOREPEAT_EN
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100,
`endif
  parameter int CNT_W       = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick_i,
  input  logic btn_s_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_MS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q, press_q, release_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);
  logic [CNT_W-1:0] rep_q;
  logic             rep_first_q;
`endif

  // A btn_s change always takes priority over a coincident ms_tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_q       <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        IDLE:
          if (btn_s_i) begin
            state_q <= ARM_HI;
            cnt_q   <= '0;
          end
        ARM_HI:
          if (!btn_s_i) state_q <= IDLE;
          else if (ms_tick_i) begin
            if (cnt_q == DB_LAST) begin
              state_q     <= PRESSED;
              level_q     <= 1'b1;
              press_q     <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
              rep_q       <= '0;
              rep_first_q <= 1'b1;
`endif
            end else cnt_q <= cnt_q + 1'b1;
          end
        PRESSED:
          if (!btn_s_i) begin
            state_q <= ARM_LO;
            cnt_q   <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (ms_tick_i) begin
            if (rep_q == (rep_first_q ? HOLD_LAST : REP_LAST)) begin
              press_q     <= 1'b1;
              rep_q       <= '0;
              rep_first_q <= 1'b0;
            end else rep_q <= rep_q + 1'b1;
          end
`endif
        ARM_LO:
          if (btn_s_i) state_q <= PRESSED;
          else if (ms_tick_i) begin
            if (cnt_q == DB_LAST) begin
              state_q   <= IDLE;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else cnt_q <= cnt_q + 1'b1;
          end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Top: div_clk edge detector (ms_tick), 2-FF button synchronisers, N_BTN debounce channels.
// BTN_AUTOREPEAT_EN enables auto-repeat press pulses in every channel.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int N_BTN       = 5,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 500,
  parameter int REPEAT_MS   = 100,
  parameter int CNT_W       = 10
) (
  input  logic clk,
  input  logic rst_n,
  button_debouncer_if.slave bus
);

  localparam int CNT_NEED = cnt_w_f(DEBOUNCE_MS, HOLD_MS, REPEAT_MS);

  // Elaboration stops here if CNT_W cannot hold the configured intervals.
  if (CNT_W < CNT_NEED) begin : g_cnt_w_too_small
    cnt_w_too_small_for_ms_parameters u_err ();
  end

  logic             t1_q, t2_q, tick_q;
  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level, press, rel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t1_q   <= 1'b0;
      t2_q   <= 1'b0;
      tick_q <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
    end else begin
      t1_q   <= bus.div_clk;
      t2_q   <= t1_q;
      tick_q <= t1_q & ~t2_q;
      s1_q   <= bus.btn_raw;
      s2_q   <= s1_q;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
`ifdef BTN_AUTOREPEAT_EN
      .HOLD_MS     (HOLD_MS),
      .REPEAT_MS   (REPEAT_MS),
`endif
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .ms_tick_i (tick_q),
      .btn_s_i   (s2_q[g]),
      .level_o   (level[g]),
      .press_o   (press[g]),
      .release_o (rel[g])
    );
  end

  assign bus.btn_level   = level;
  assign bus.btn_press   = press;
  assign bus.btn_release = rel;
  assign bus.ms_tick     = tick_q;

endmodule
